// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: system-clock sequencer for the SPI slave shift core.
// Brings the core's chip-select and word-done flags into clk_i, decodes each
// frame as command / address / data words, and drives a register-file port.
// Write bursts auto-increment the address; read bursts fetch register data
// into the core's transmit word, one register per dummy word clocked by the master.
module spi_cmd_ctrl #(
    parameter int                   WORD_SIZE   = 8,
    parameter int                   ADDR_W      = 7,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [WORD_SIZE-1:0] CMD_WRITE   = 8'h02,
    parameter logic [WORD_SIZE-1:0] CMD_READ    = 8'h03
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_i,
    input  logic                 rxtx_done_i,
    input  logic [WORD_SIZE-1:0] rx_word_i,
    output logic [WORD_SIZE-1:0] tx_word_o,
    output logic [ADDR_W-1:0]    reg_addr_o,
    output logic [WORD_SIZE-1:0] reg_wdata_o,
    output logic                 reg_we_o,
    output logic                 reg_re_o,
    input  logic [WORD_SIZE-1:0] reg_rdata_i,
    output logic                 frame_active_o,
    output logic                 cmd_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WR_DATA,
        RD_DATA,
        ERR
    } state_t;

    state_t                 state;
    logic                   mode_rd;     // burst direction chosen by the command word
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] done_sync;
    logic                   cs_prev;
    logic                   done_prev;
    logic                   word_ev;     // word captured last cycle, acted on this cycle
    logic [WORD_SIZE-1:0]   word_q;

    logic cs_s;
    logic done_s;
    logic cs_fall;
    logic done_rise;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign done_s    = done_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_s;
    assign done_rise = done_s & ~done_prev;

    // Synchronisers, edge detection, word capture and the frame FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sync flops reset to 0 (not to the idle-high level of cs) so that a cs
            // held low through reset cannot fake a frame start; a real high->low is required.
            cs_sync        <= '0;
            done_sync      <= '0;
            cs_prev        <= 1'b0;
            done_prev      <= 1'b0;
            word_ev        <= 1'b0;
            word_q         <= '0;
            mode_rd        <= 1'b0;
            state          <= IDLE;
            tx_word_o      <= '0;
            reg_addr_o     <= '0;
            reg_wdata_o    <= '0;
            reg_we_o       <= 1'b0;
            reg_re_o       <= 1'b0;
            frame_active_o <= 1'b0;
            cmd_err_o      <= 1'b0;
        end else begin
            // NOTE: every state element here uses <=, so all branches see the pre-edge
            // values and the statement order below only matters for later-wins overrides.
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
            done_sync <= {done_sync[SYNC_STAGES-2:0], rxtx_done_i};
            cs_prev   <= cs_s;
            done_prev <= done_s;

            // Strobes last exactly one cycle.
            reg_we_o <= 1'b0;
            reg_re_o <= 1'b0;

            // Post-strobe bookkeeping: a completed write advances the address,
            // a completed read lands the register data in the transmit word.
            if (reg_we_o) begin
                reg_addr_o <= reg_addr_o + 1'b1;
            end
            if (reg_re_o) begin
                tx_word_o <= reg_rdata_i;
            end

            if (cs_s) begin
                // Deselect wins over everything, including a coincident word.
                state          <= IDLE;
                frame_active_o <= 1'b0;
                word_ev        <= 1'b0;
            end else if (cs_fall) begin
                state          <= CMD;
                frame_active_o <= 1'b1;
                cmd_err_o      <= 1'b0;
                tx_word_o      <= '0;
                word_ev        <= 1'b0;
            end else begin
                word_ev <= done_rise;
                if (done_rise) begin
                    word_q <= rx_word_i;
                end

                if (word_ev) begin
                    case (state)
                        CMD: begin
                            if (word_q == CMD_WRITE) begin
                                mode_rd <= 1'b0;
                                state   <= ADDR;
                            end else if (word_q == CMD_READ) begin
                                mode_rd <= 1'b1;
                                state   <= ADDR;
                            end else begin
                                cmd_err_o <= 1'b1;
                                state     <= ERR;
                            end
                        end
                        ADDR: begin
                            reg_addr_o <= word_q[ADDR_W-1:0];
                            if (mode_rd) begin
                                reg_re_o <= 1'b1;
                                state    <= RD_DATA;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                        WR_DATA: begin
                            reg_wdata_o <= word_q;
                            reg_we_o    <= 1'b1;
                        end
                        RD_DATA: begin
                            // The incoming word is a dummy; it only paces the next fetch.
                            reg_addr_o <= reg_addr_o + 1'b1;
                            reg_re_o   <= 1'b1;
                        end
                        default: begin
                            // IDLE and ERR ignore words.
                        end
                    endcase
                end
            end
        end
    end

endmodule
